// File: rtl/frame_buf_sched.sv
`default_nettype none
// ============================================================================
// Module   : frame_buf_sched
// Purpose  : Ping-pong display buffer scheduler: scan counters, front/back
//            swap at frame boundaries, one-hot Bigmux selects, read address.
// Revision : 1.0 - initial release
// ============================================================================
module frame_buf_sched #(
  parameter int H_ACTIVE = 4,
  parameter int H_BLANK  = 2,
  parameter int V_ACTIVE = 3,
  parameter int V_BLANK  = 1,
  parameter int AW       = 4
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          Enable,
  input  logic          WrDone,
  output logic          WrBuf,
  output logic          BufRelease,
  output logic          SelBuf0,
  output logic          SelBuf1,
  output logic          SelBlank,
  output logic [AW-1:0] RdAddr,
  output logic          FrameStart,
  output logic          Overrun,
  output logic [7:0]    RepeatCnt
);

  localparam int H_TOTAL = H_ACTIVE + H_BLANK;
  localparam int V_TOTAL = V_ACTIVE + V_BLANK;
  localparam int HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int VW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_C = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT_C = VW'(V_ACTIVE);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic          front_q, front_d;
  logic          wrbuf_q, wrbuf_d;
  logic          ready_q, ready_d;
  logic [7:0]    rep_q, rep_d;
  logic          rel_q, rel_d;
  logic          ovr_q, ovr_d;
  logic          sel0_q, sel0_d;
  logic          sel1_q, sel1_d;
  logic          blank_q, blank_d;
  logic          fs_q, fs_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] pix_q, pix_d;

  logic          w_ready;
  logic          w_frame_end;
  logic          w_active;
  logic          w_origin;
  logic [AW-1:0] w_base;

  assign w_ready     = ready_q | WrDone;
  assign w_frame_end = (hcnt_q == H_LAST) && (vcnt_q == V_LAST);

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;
    front_d = front_q;
    wrbuf_d = wrbuf_q;
    ready_d = ready_q;
    rep_d   = rep_q;
    rel_d   = 1'b0;
    ovr_d   = WrDone & ready_q;

    case (state_q)
      S_IDLE: begin
        hcnt_d = '0;
        vcnt_d = '0;
        if (Enable && w_ready) begin
          state_d = S_RUN;
          front_d = wrbuf_q;
          wrbuf_d = front_q;
          ready_d = 1'b0;
          rel_d   = 1'b1;
        end else begin
          ready_d = w_ready;
        end
      end
      S_RUN: begin
        if (w_frame_end) begin
          hcnt_d = '0;
          vcnt_d = '0;
          // A WrDone landing on the frame-end cycle still makes this swap.
          if (w_ready) begin
            front_d = wrbuf_q;
            wrbuf_d = front_q;
            ready_d = 1'b0;
            rel_d   = 1'b1;
          end else if (rep_q != 8'hFF) begin
            rep_d = rep_q + 8'd1;
          end
          if (!Enable) begin
            state_d = S_IDLE;
          end
        end else begin
          ready_d = w_ready;
          if (hcnt_q == H_LAST) begin
            hcnt_d = '0;
            vcnt_d = vcnt_q + VW'(1);
          end else begin
            hcnt_d = hcnt_q + HW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are computed from the next scan position so they line up with it.
  assign w_origin = (hcnt_d == '0) && (vcnt_d == '0);
  assign w_active = (state_d == S_RUN) && (hcnt_d < H_ACT_C) && (vcnt_d < V_ACT_C);
  assign w_base   = ((state_d != S_RUN) || w_origin) ? '0 : pix_q;

  always_comb begin
    fs_d    = (state_d == S_RUN) && w_origin;
    sel0_d  = w_active & ~front_d;
    sel1_d  = w_active & front_d;
    blank_d = ~w_active;
    addr_d  = w_active ? w_base : '0;
    pix_d   = w_active ? (w_base + AW'(1)) : w_base;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      front_q <= 1'b0;
      wrbuf_q <= 1'b1;
      ready_q <= 1'b0;
      rep_q   <= '0;
      rel_q   <= 1'b0;
      ovr_q   <= 1'b0;
      sel0_q  <= 1'b0;
      sel1_q  <= 1'b0;
      blank_q <= 1'b1;
      fs_q    <= 1'b0;
      addr_q  <= '0;
      pix_q   <= '0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      front_q <= front_d;
      wrbuf_q <= wrbuf_d;
      ready_q <= ready_d;
      rep_q   <= rep_d;
      rel_q   <= rel_d;
      ovr_q   <= ovr_d;
      sel0_q  <= sel0_d;
      sel1_q  <= sel1_d;
      blank_q <= blank_d;
      fs_q    <= fs_d;
      addr_q  <= addr_d;
      pix_q   <= pix_d;
    end
  end

  assign WrBuf      = wrbuf_q;
  assign BufRelease = rel_q;
  assign SelBuf0    = sel0_q;
  assign SelBuf1    = sel1_q;
  assign SelBlank   = blank_q;
  assign RdAddr     = addr_q;
  assign FrameStart = fs_q;
  assign Overrun    = ovr_q;
  assign RepeatCnt  = rep_q;

endmodule
`default_nettype wire

// File: tb/tb_frame_buf_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_buf_sched
// Purpose  : Randomized + directed bench for frame_buf_sched against a
//            position/arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_frame_buf_sched;

  localparam int HA = 4, HB = 2, VA = 3, VB = 1, AW = 4;
  localparam int HT = HA + HB, VT = VA + VB;

  logic          Clk = 1'b0;
  logic          Reset_n = 1'b0;
  logic          Enable = 1'b0;
  logic          WrDone = 1'b0;
  logic          WrBuf, BufRelease, SelBuf0, SelBuf1, SelBlank;
  logic [AW-1:0] RdAddr;
  logic          FrameStart, Overrun;
  logic [7:0]    RepeatCnt;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit m_run, m_front, m_wrbuf, m_ready, m_rel, m_ovr;
  int m_h, m_v, m_rep;

  frame_buf_sched #(.H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(VB), .AW(AW)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Enable(Enable), .WrDone(WrDone),
    .WrBuf(WrBuf), .BufRelease(BufRelease), .SelBuf0(SelBuf0), .SelBuf1(SelBuf1),
    .SelBlank(SelBlank), .RdAddr(RdAddr), .FrameStart(FrameStart), .Overrun(Overrun),
    .RepeatCnt(RepeatCnt)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_front = 0; m_wrbuf = 1; m_ready = 0;
    m_rel = 0; m_ovr = 0; m_h = 0; m_v = 0; m_rep = 0;
  endtask

  task automatic model_swap();
    bit t;
    t = m_front; m_front = m_wrbuf; m_wrbuf = t;
    m_ready = 0; m_rel = 1;
  endtask

  task automatic model_step(input bit en, input bit wd);
    bit rdy;
    rdy   = m_ready | wd;
    m_ovr = wd & m_ready;
    m_rel = 0;
    if (!m_run) begin
      if (en && rdy) begin
        model_swap();
        m_run = 1; m_h = 0; m_v = 0;
      end else m_ready = rdy;
    end else if (m_h == HT - 1 && m_v == VT - 1) begin
      if (rdy) model_swap();
      else if (m_rep < 255) m_rep++;
      m_h = 0; m_v = 0;
      if (!en) m_run = 0;
    end else begin
      m_ready = rdy;
      m_h++;
      if (m_h == HT) begin m_h = 0; m_v++; end
    end
  endtask

  task automatic compare_all();
    bit act;
    act = m_run && m_h < HA && m_v < VA;
    check("SelBuf0",    SelBuf0,    act && !m_front);
    check("SelBuf1",    SelBuf1,    act && m_front);
    check("SelBlank",   SelBlank,   !act);
    check("onehot",     int'(SelBuf0) + int'(SelBuf1) + int'(SelBlank), 1);
    check("RdAddr",     RdAddr,     act ? m_v * HA + m_h : 0);
    check("FrameStart", FrameStart, m_run && m_h == 0 && m_v == 0);
    check("BufRelease", BufRelease, m_rel);
    check("Overrun",    Overrun,    m_ovr);
    check("WrBuf",      WrBuf,      m_wrbuf);
    check("RepeatCnt",  RepeatCnt,  m_rep);
  endtask

  // Called at a negedge: inputs apply to the next posedge.
  task automatic cycle(input bit en, input bit wd);
    Enable = en; WrDone = wd;
    @(posedge Clk);
    if (Reset_n) model_step(en, wd); else model_reset();
    @(negedge Clk);
    compare_all();
  endtask

  // Advance (Enable=1, no WrDone) until the model holds position (h,v).
  task automatic run_to(input int h, input int v);
    int n = 0;
    while (!(m_run && m_h == h && m_v == v) && n < 100) begin
      cycle(1, 0);
      n++;
    end
    check("run_to_timeout", n < 100, 1);
  endtask

  task automatic do_reset();
    Reset_n = 0; Enable = 0; WrDone = 0;
    @(negedge Clk);
    model_reset();
    compare_all();
    @(negedge Clk);
    Reset_n = 1;
  endtask

  initial begin
    model_reset();
    do_reset();

    // Idle with Enable but no data: always blank, nothing repeated.
    for (int i = 0; i < 50; i++) cycle(1, 0);

    // First frame, then a frame with nothing new (repeat).
    for (int i = 0; i < 5; i++) cycle(1, 0);
    cycle(1, 1);
    check("first_front_buf1", SelBuf1, 1);
    for (int i = 0; i < 2 * HT * VT; i++) cycle(1, 0);

    // WrDone mid-frame -> swap at next frame start.
    run_to(3, 1);
    cycle(1, 1);
    run_to(0, 0);

    // WrDone exactly on the frame-end cycle.
    run_to(HT - 1, VT - 1);
    cycle(1, 1);

    // Two WrDone pulses within one frame.
    run_to(1, 0);
    cycle(1, 1);
    cycle(1, 0);
    cycle(1, 1);
    run_to(0, 0);
    run_to(0, 0);

    // Enable dropped mid-frame: finish the frame, then idle.
    run_to(2, 1);
    cycle(0, 0);
    for (int i = 0; i < HT * VT; i++) cycle(0, 0);
    check("idle_after_drop", m_run, 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 9) != 0, $urandom_range(0, 14) == 0);

    // Saturate RepeatCnt.
    cycle(1, 1);
    for (int i = 0; i < 262 * HT * VT; i++) cycle(1, 0);
    check("rep_saturated", RepeatCnt, 255);

    // Asynchronous reset in the middle of a frame.
    cycle(1, 1);
    run_to(2, 1);
    check("addr_before_reset", RdAddr, 6);
    #2 Reset_n = 0;
    #1;
    model_reset();
    compare_all();
    @(negedge Clk);
    compare_all();
    Reset_n = 1;
    for (int i = 0; i < 3 * HT * VT; i++) cycle(1, 0);
    for (int i = 0; i < 500; i++)
      cycle($urandom_range(0, 7) != 0, $urandom_range(0, 10) == 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/frame_buf_sched.md
Name: frame_buf_sched

Overview:
- Ping-pong display buffer scheduler that drives the 3-way frame multiplexer select lines (SelBuf0, SelBuf1, SelBlank) and the pixel read address.
- Runs horizontal/vertical scan counters, shows the front buffer during the active region and blank during blanking, and swaps front/back only at frame boundaries once the writer has signalled the back buffer complete.
- Sits between the frame-buffer writer and the Bigmux output stage.

Parameters:
- H_ACTIVE, 4, active pixels per line
- H_BLANK, 2, blank pixels per line
- V_ACTIVE, 3, active lines per frame
- V_BLANK, 1, blank lines per frame
- AW, 4, RdAddr width; must satisfy 2^AW >= H_ACTIVE*V_ACTIVE

Ports:
- Clk  input  1  system clock; single clock domain
- Reset_n  input  1  reset, asynchronous assert, active-low
- Enable  input  1  scan enable; sampled in IDLE and at frame end
- WrDone  input  1  one-cycle pulse: writer finished filling buffer WrBuf
- WrBuf  output  1  index of the back buffer the writer may fill
- BufRelease  output  1  one-cycle pulse: WrBuf just changed; new back buffer is free
- SelBuf0  output  1  mux select, front buffer 0
- SelBuf1  output  1  mux select, front buffer 1
- SelBlank  output  1  mux select, blank (zero) pixel
- RdAddr  output  AW  pixel read address into the front buffer
- FrameStart  output  1  high for the cycle at position (0,0)
- Overrun  output  1  one-cycle pulse: WrDone arrived while back buffer already ready
- RepeatCnt  output  8  saturating count of frames repeated because the back buffer was not ready

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_BLANK; V_TOTAL = V_ACTIVE+V_BLANK.
- HCnt wraps H_TOTAL-1 -> 0 and then increments VCnt; VCnt wraps V_TOTAL-1 -> 0.
- Internal state: Front (1 bit), BackReady (1 bit), FSM {IDLE, RUN}.
- Async reset values: FSM=IDLE, HCnt=VCnt=0, Front=0, WrBuf=1, BackReady=0, SelBlank=1, SelBuf0=SelBuf1=0, RdAddr=0, FrameStart=0, BufRelease=0, Overrun=0, RepeatCnt=0.
- All outputs are registered. The outputs present in cycle t describe the scan position held in cycle t.
- Select lines are one-hot at all times, including IDLE and the cycle after reset. The all-zero case must never occur, because the mux holds its previous value on that case.
- Active region: HCnt<H_ACTIVE && VCnt<V_ACTIVE.
  - Selection: SelBuf0 if Front=0, SelBuf1 if Front=1.
  - RdAddr = VCnt*H_ACTIVE + HCnt, maintained as an incrementing counter with no multiplier.
- Blank region: SelBlank=1; RdAddr holds 0.
- WrDone handling:
  - BackReady=0: set BackReady.
  - BackReady=1: Overrun pulses the next cycle; BackReady stays 1.
- IDLE: counters held at 0, SelBlank=1. Move to RUN when Enable=1 and (BackReady=1 or WrDone=1). On that transition:
  - Front <= WrBuf; WrBuf <= old Front; BackReady <= 0.
  - BufRelease pulses in the first RUN cycle.
  - The first RUN cycle is position (0,0) with FrameStart=1.
- RUN, frame-end cycle (HCnt=H_TOTAL-1, VCnt=V_TOTAL-1):
  - WrDone in this cycle counts as ready before the swap decision.
  - Ready: swap Front/WrBuf, clear BackReady, pulse BufRelease next cycle.
  - Not ready: Front is unchanged and RepeatCnt increments, saturating at 255.
  - Enable=0: go to IDLE after the swap decision; counters reset to 0.
  - Enable=1: continue at (0,0) with FrameStart=1.
- Enable deasserted mid-frame: the current frame finishes. IDLE is entered only at the frame boundary.
- WrBuf never changes outside a swap, so the writer never targets the displayed buffer.
- Reset asserted mid-frame: immediate return to reset values. The next frame needs a new WrDone.

Test Plan:
- Reset, Enable=1, no WrDone for 50 cycles:
  - SelBlank=1 and SelBuf0=SelBuf1=0 every cycle.
  - WrBuf=1, RepeatCnt=0.
- WrDone at cycle 5 with Enable=1:
  - Next cycle: RUN, FrameStart=1, SelBuf1=1, RdAddr=0, BufRelease=1, WrBuf=0.
  - RdAddr runs 0,1,2,3, then 2 blank cycles, then 4..7.
  - Line 3 (VCnt=3) is all SelBlank.
  - Frame length is 24 cycles.
- No WrDone during the second frame:
  - At (0,0), SelBuf1 is still selected, RepeatCnt=1, no BufRelease.
- WrDone during the second frame:
  - Next frame selects SelBuf0, BufRelease=1 at (0,0), WrBuf=1.
- WrDone exactly on the frame-end cycle:
  - Swap occurs at the next (0,0).
- Two WrDone pulses within one frame:
  - Overrun pulses once.
  - Exactly one swap at frame end.
- Enable dropped at HCnt=2, VCnt=1:
  - Scan completes to (5,3), then enters IDLE with SelBlank=1.
- Reset_n asserted at RdAddr=6:
  - Outputs take reset values asynchronously, without waiting for a Clk edge.
